// File: rtl/mat_mul_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : mat_mul_scheduler
// Description : Operand sequencer and accumulator for a 4x4 complex matrix
//               multiply sharing one fixed-latency complex multiplier.
// Revision    : 1.0 - initial release
// ============================================================================
module mat_mul_scheduler #(
  parameter int INTEGER_SIZE = 7,
  parameter int FRACT_SIZE   = 11,
  parameter int DATA_WIDTH   = INTEGER_SIZE + FRACT_SIZE,
  parameter int MUL_LAT      = 3
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           Start_Mul,
  output logic [1:0]                     a_row,
  output logic [1:0]                     b_col,
  output logic [1:0]                     k_idx,
  output logic                           op_valid,
  input  logic signed [2*DATA_WIDTH-1:0] prod_r,
  input  logic signed [2*DATA_WIDTH-1:0] prod_i,
  input  logic                           prod_valid,
  output logic [DATA_WIDTH-1:0]          Serial_Matrix_Out_r,
  output logic [DATA_WIDTH-1:0]          Serial_Matrix_Out_i,
  output logic                           valid,
  output logic                           done,
  output logic                           busy
);

  localparam int c_PROD_W = 2 * DATA_WIDTH;
  localparam int c_ACC_W  = 2 * DATA_WIDTH + 2;

  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_ISSUE = 2'd1;
  localparam logic [1:0] c_DRAIN = 2'd2;

  localparam logic signed [c_ACC_W:0] c_RND =
    {{(c_ACC_W + 1 - FRACT_SIZE){1'b0}}, 1'b1, {(FRACT_SIZE - 1){1'b0}}};
  localparam logic signed [c_ACC_W:0] c_SAT_MAX =
    {{(c_ACC_W + 2 - DATA_WIDTH){1'b0}}, {(DATA_WIDTH - 1){1'b1}}};
  localparam logic signed [c_ACC_W:0] c_SAT_MIN =
    {{(c_ACC_W + 2 - DATA_WIDTH){1'b1}}, {(DATA_WIDTH - 1){1'b0}}};

  logic [1:0]                  r_state;
  logic [5:0]                  r_issue_cnt;
  logic [6:0]                  r_prod_cnt;
  logic [7:0]                  r_drain_cnt;
  logic signed [c_ACC_W-1:0]   r_acc_r;
  logic signed [c_ACC_W-1:0]   r_acc_i;
  logic [DATA_WIDTH-1:0]       r_out_r;
  logic [DATA_WIDTH-1:0]       r_out_i;
  logic                        r_valid;
  logic                        r_done;

  logic signed [c_ACC_W-1:0]   w_prod_r_ext;
  logic signed [c_ACC_W-1:0]   w_prod_i_ext;
  logic signed [c_ACC_W-1:0]   w_sum_r;
  logic signed [c_ACC_W-1:0]   w_sum_i;
  logic                        w_first;
  logic                        w_accept;

  // Round half up at the result LSB, then clamp to the result range.
  function automatic logic [DATA_WIDTH-1:0] round_sat(input logic signed [c_ACC_W-1:0] v);
    logic signed [c_ACC_W:0] t;
    t = $signed({v[c_ACC_W-1], v}) + c_RND;
    t = t >>> FRACT_SIZE;
    if (t > c_SAT_MAX)
      round_sat = c_SAT_MAX[DATA_WIDTH-1:0];
    else if (t < c_SAT_MIN)
      round_sat = c_SAT_MIN[DATA_WIDTH-1:0];
    else
      round_sat = t[DATA_WIDTH-1:0];
  endfunction

  assign w_prod_r_ext = {{2{prod_r[c_PROD_W-1]}}, prod_r};
  assign w_prod_i_ext = {{2{prod_i[c_PROD_W-1]}}, prod_i};
  assign w_first      = (r_prod_cnt[1:0] == 2'd0);
  assign w_sum_r      = w_first ? w_prod_r_ext : r_acc_r + w_prod_r_ext;
  assign w_sum_i      = w_first ? w_prod_i_ext : r_acc_i + w_prod_i_ext;
  // Products past the 64th of a run, or arriving while idle, are dropped.
  assign w_accept     = prod_valid && (r_state != c_IDLE) && !r_prod_cnt[6];

  assign op_valid               = (r_state == c_ISSUE);
  assign {a_row, b_col, k_idx}  = op_valid ? r_issue_cnt : 6'd0;
  assign busy                   = (r_state != c_IDLE);
  assign Serial_Matrix_Out_r    = r_out_r;
  assign Serial_Matrix_Out_i    = r_out_i;
  assign valid                  = r_valid;
  assign done                   = r_done;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= c_IDLE;
      r_issue_cnt <= 6'd0;
      r_prod_cnt  <= 7'd0;
      r_drain_cnt <= 8'd0;
      r_acc_r     <= '0;
      r_acc_i     <= '0;
      r_out_r     <= '0;
      r_out_i     <= '0;
      r_valid     <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      r_done  <= 1'b0;

      case (r_state)
        c_IDLE: begin
          if (Start_Mul) begin
            r_state     <= c_ISSUE;
            r_issue_cnt <= 6'd0;
            r_prod_cnt  <= 7'd0;
            r_drain_cnt <= 8'd0;
          end
        end
        c_ISSUE: begin
          r_issue_cnt <= r_issue_cnt + 6'd1;
          if (r_issue_cnt == 6'd63)
            r_state <= c_DRAIN;
        end
        c_DRAIN: begin
          // Leaving on a fixed count keeps the FSM from hanging on a lost product.
          r_drain_cnt <= r_drain_cnt + 8'd1;
          if (r_drain_cnt == 8'(MUL_LAT))
            r_state <= c_IDLE;
        end
        default: r_state <= c_IDLE;
      endcase

      if (w_accept) begin
        r_prod_cnt <= r_prod_cnt + 7'd1;
        r_acc_r    <= w_sum_r;
        r_acc_i    <= w_sum_i;
        if (r_prod_cnt[1:0] == 2'd3) begin
          r_out_r <= round_sat(w_sum_r);
          r_out_i <= round_sat(w_sum_i);
          r_valid <= 1'b1;
          if (r_prod_cnt[5:0] == 6'd63)
            r_done <= 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire
